// File: rtl/mux_n_hs_pkg.sv
// Shared constants and helpers for the handshake N-to-1 multiplexer.
// Latency: n/a (package). Backpressure: n/a.
// Provides selection-mode encodings and width helpers used by the interface, arbiter and top.
package mux_n_pkg;

  localparam int MUX_MODE_SEL  = 0;  // external sel picks the channel
  localparam int MUX_MODE_RR   = 1;  // round-robin from a rotating pointer
  localparam int MUX_MODE_PRIO = 2;  // lowest valid index wins

  // Ceiling log2: smallest r with 2**r >= n.
  function automatic int mux_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of channel indices; never narrower than one bit.
  function automatic int mux_sel_w(input int n);
    return (mux_clog2(n) < 1) ? 1 : mux_clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_hs_if.sv
// Bundle of the per-channel input handshakes, the select, and the output handshake.
// Latency: n/a (wires only). Backpressure: carried by in_ready/out_ready.
// Ports: sel, in_data, in_valid, in_ready, out_data, out_valid, out_ready, out_chan.
interface mux_n_hs_if
  import mux_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) ();

  localparam int SEL_W = mux_sel_w(N);

  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_chan;

  // Mux side: consumes the channels and the downstream ready.
  modport slave (
    input  sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

  // Environment side: producers plus downstream consumer.
  modport master (
    output sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

endinterface

// File: rtl/mux_n_hs_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or above ptr, wrapping N-1 -> 0.
// Latency: 0 clk (pure combinational). Backpressure: none; caller gates the grant.
// Ports: req[N] in, ptr[SEL_W] in (must be < N), grant[N] one-hot out, gidx[SEL_W] out, any out.
module rr_arbiter
  import mux_n_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = mux_sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gidx,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;
  logic             hit;

  // Modulo-N add; both operands are < N so one conditional subtract suffices,
  // which keeps the wrap correct for non-power-of-2 N.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then map back.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[wrap_add(ptr, SEL_W'(j))];
    end
  end

  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!hit && rot[j]) begin
        hit = 1'b1;
        off = SEL_W'(j);
      end
    end
  end

  always_comb begin
    gidx  = wrap_add(ptr, off);
    any   = hit;
    grant = '0;
    if (hit) grant[gidx] = 1'b1;
  end

endmodule

// File: rtl/mux_n_hs.sv
// N-to-1 valid/ready multiplexer with external-select, round-robin or fixed-priority choice.
// Latency: 1 clk from input handshake to out_valid; 1 word/clk sustained.
// Backpressure: while out_valid && !out_ready every in_ready is low and the output holds.
// Ports: clk, rst_n (async active-low), bus (mux_n_hs_if.slave).
module mux_n_hs
  import mux_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = MUX_MODE_RR
) (
  input logic         clk,
  input logic         rst_n,
  mux_n_hs_if.slave   bus
);

  localparam int SEL_W = mux_sel_w(N);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] out_chan_q;
  logic [SEL_W-1:0] ptr_q;

  logic [N-1:0]     grant_sel;
  logic [N-1:0]     arb_grant;
  logic [SEL_W-1:0] arb_gidx;
  logic [SEL_W-1:0] arb_ptr;
  logic             arb_any;

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] gidx;
  logic             any;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  // Fixed priority is round-robin with the search always starting at channel 0.
  assign arb_ptr = (MODE == MUX_MODE_PRIO) ? '0 : ptr_q;

  rr_arbiter #(.N(N)) u_arb (
    .req   (bus.in_valid),
    .ptr   (arb_ptr),
    .grant (arb_grant),
    .gidx  (arb_gidx),
    .any   (arb_any)
  );

  // External select; indices N..2**SEL_W-1 grant nothing.
  always_comb begin
    grant_sel = '0;
    if (int'(bus.sel) < N) grant_sel[bus.sel] = bus.in_valid[bus.sel];
  end

  always_comb begin
    if (MODE == MUX_MODE_SEL) begin
      grant = grant_sel;
      gidx  = bus.sel;
      any   = |grant_sel;
    end else begin
      grant = arb_grant;
      gidx  = arb_gidx;
      any   = arb_any;
    end
  end

  // Output register can take a word when empty or being drained this cycle.
  assign load = !out_valid_q || bus.out_ready;
  // Readies are held low during reset even though the register reads empty.
  assign bus.in_ready = (rst_n && load) ? grant : '0;
  assign xfer = rst_n && load && any;

  // One-hot AND-OR data select avoids an out-of-range part-select when sel >= N.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) mux_data = mux_data | bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_data_q  <= mux_data;
      out_chan_q  <= gidx;
      out_valid_q <= 1'b1;
      // Pointer moves just past the winner so it becomes lowest priority next time.
      if (int'(gidx) == N - 1) ptr_q <= '0;
      else                     ptr_q <= gidx + SEL_W'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_n_hs.sv
// Bench for mux_n_hs: three instances (N=4 round-robin, N=4 priority, N=3 external select)
// driven in lockstep; a reference grant model feeds per-instance expected-output queues.
module tb_mux_n_hs;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Stimulus per instance k: 0 = RR (N=4), 1 = PRIO (N=4), 2 = SEL (N=3)
  logic [2:0][3:0]  t_vld;
  logic [2:0][31:0] t_dat;
  logic [2:0]       t_ordy;
  logic [2:0][1:0]  t_sel;

  wire [2:0][3:0] o_rdy;
  wire [2:0][7:0] o_dat;
  wire [2:0]      o_vld;
  wire [2:0][1:0] o_chan;

  mux_n_hs_if #(.WIDTH(8), .N(4)) bus0 ();
  mux_n_hs_if #(.WIDTH(8), .N(4)) bus1 ();
  mux_n_hs_if #(.WIDTH(8), .N(3)) bus2 ();

  mux_n_hs #(.WIDTH(8), .N(4), .MODE(1)) dut_rr   (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_n_hs #(.WIDTH(8), .N(4), .MODE(2)) dut_prio (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_n_hs #(.WIDTH(8), .N(3), .MODE(0)) dut_sel  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.in_valid  = t_vld[0];
  assign bus0.in_data   = t_dat[0];
  assign bus0.out_ready = t_ordy[0];
  assign bus0.sel       = t_sel[0];
  assign bus1.in_valid  = t_vld[1];
  assign bus1.in_data   = t_dat[1];
  assign bus1.out_ready = t_ordy[1];
  assign bus1.sel       = t_sel[1];
  assign bus2.in_valid  = t_vld[2][2:0];
  assign bus2.in_data   = t_dat[2][23:0];
  assign bus2.out_ready = t_ordy[2];
  assign bus2.sel       = t_sel[2];

  assign o_rdy[0]  = bus0.in_ready;
  assign o_rdy[1]  = bus1.in_ready;
  assign o_rdy[2]  = {1'b0, bus2.in_ready};
  assign o_dat[0]  = bus0.out_data;
  assign o_dat[1]  = bus1.out_data;
  assign o_dat[2]  = bus2.out_data;
  assign o_vld[0]  = bus0.out_valid;
  assign o_vld[1]  = bus1.out_valid;
  assign o_vld[2]  = bus2.out_valid;
  assign o_chan[0] = bus0.out_chan;
  assign o_chan[1] = bus1.out_chan;
  assign o_chan[2] = bus2.out_chan;

  int checks   = 0;
  int failures = 0;

  // Reference state
  bit m_ov  [3];
  int m_ptr [3];
  logic [9:0] sb0[$];
  logic [9:0] sb1[$];
  logic [9:0] sb2[$];

  function automatic int ns(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic int mode_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [9:0] sb_front(input int k);
    case (k)
      0:       return sb0[0];
      1:       return sb1[0];
      default: return sb2[0];
    endcase
  endfunction

  task automatic sb_push(input int k, input logic [9:0] v);
    case (k)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int k);
    case (k)
      0:       void'(sb0.pop_front());
      1:       void'(sb1.pop_front());
      default: void'(sb2.pop_front());
    endcase
  endtask

  // Independent statement of the grant rule for each mode.
  function automatic int model_grant(input int k);
    int n;
    n = ns(k);
    case (mode_of(k))
      0: begin
        if (int'(t_sel[k]) < n && t_vld[k][t_sel[k]]) return int'(t_sel[k]);
      end
      1: begin
        for (int o = 0; o < n; o++) begin
          int idx;
          idx = (m_ptr[k] + o) % n;
          if (t_vld[k][idx]) return idx;
        end
      end
      default: begin
        for (int i = 0; i < n; i++) begin
          if (t_vld[k][i]) return i;
        end
      end
    endcase
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs/readies against the model just before the edge,
  // push the word the model says is accepted, pop the word being drained.
  task automatic step();
    #1;
    for (int k = 0; k < 3; k++) begin
      int         g;
      bit         ld;
      logic [3:0] exp_rdy;
      logic [9:0] fr;
      g  = model_grant(k);
      ld = !m_ov[k] || t_ordy[k];
      chk($sformatf("out_valid[%0d]", k), 32'(o_vld[k]), 32'(m_ov[k]));
      if (m_ov[k]) begin
        chk($sformatf("sb_depth[%0d]", k), 32'(sb_size(k)), 32'd1);
        if (sb_size(k) > 0) begin
          fr = sb_front(k);
          chk($sformatf("out_data[%0d]", k), 32'(o_dat[k]), 32'(fr[7:0]));
          chk($sformatf("out_chan[%0d]", k), 32'(o_chan[k]), 32'(fr[9:8]));
        end
      end
      exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
      chk($sformatf("in_ready[%0d]", k), 32'(o_rdy[k]), 32'(exp_rdy));
      if (m_ov[k] && t_ordy[k] && sb_size(k) > 0) sb_pop(k);
      if (ld && g >= 0) begin
        sb_push(k, {2'(g), t_dat[k][g*8 +: 8]});
        m_ov[k]  = 1'b1;
        m_ptr[k] = (g == ns(k) - 1) ? 0 : g + 1;
      end else if (m_ov[k] && t_ordy[k]) begin
        m_ov[k] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge.
  task automatic reset_check();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), 32'(o_vld[k]), 32'd0);
      chk($sformatf("rst_out_data[%0d]", k), 32'(o_dat[k]), 32'd0);
      chk($sformatf("rst_out_chan[%0d]", k), 32'(o_chan[k]), 32'd0);
      chk($sformatf("rst_in_ready[%0d]", k), 32'(o_rdy[k]), 32'd0);
      m_ov[k]  = 1'b0;
      m_ptr[k] = 0;
    end
    sb0.delete();
    sb1.delete();
    sb2.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_all(input logic [3:0] vld, input logic [31:0] dat, input logic ordy);
    for (int k = 0; k < 3; k++) begin
      t_vld[k]  = vld;
      t_dat[k]  = dat;
      t_ordy[k] = ordy;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    t_vld  = '0;
    t_dat  = '0;
    t_ordy = '0;
    t_sel  = '0;
    @(negedge clk);
    reset_check();

    // Idle after release: nothing offered, nothing accepted.
    steps(2);

    // All channels valid, consumer always ready: RR rotates 0,1,2,3; PRIO sticks to 0.
    set_all(4'hF, 32'hA3A2A1A0, 1'b1);
    t_sel[2] = 2'd0;
    steps(9);

    // Reset while holding a word with valids still high.
    reset_check();
    set_all(4'h0, 32'hA3A2A1A0, 1'b1);
    steps(2);

    // Only ch1 and ch3: RR alternates and wraps 3->0; then ch1 alone, no bubbles.
    set_all(4'b1010, 32'hB3B2B1B0, 1'b1);
    t_sel[2] = 2'd1;
    steps(6);
    set_all(4'b0010, 32'hC3C2C1C0, 1'b1);
    steps(4);

    // Backpressure: load one word, stall 3 clks while sel toggles, then release.
    set_all(4'b0101, 32'h44223311, 1'b1);
    t_sel[2] = 2'd2;
    step();
    for (int k = 0; k < 3; k++) t_ordy[k] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_sel[2] = 2'(i);
      step();
    end
    t_sel[2] = 2'd2;
    for (int k = 0; k < 3; k++) t_ordy[k] = 1'b1;
    steps(4);

    // Out-of-range select on the N=3 instance: no grant, output drains.
    set_all(4'hF, 32'hD3D2D1D0, 1'b1);
    t_sel[2] = 2'd3;
    steps(3);

    // Random valid/ready/select/data across all instances.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        t_vld[k]  = 4'($urandom);
        t_dat[k]  = $urandom;
        t_ordy[k] = ($urandom_range(0, 3) != 0);
        t_sel[k]  = 2'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_hs.md
Name: mux_n_hs

Overview:
- Parametrised N-to-1 data multiplexer, the successor of the basic 2:1 mux.
- Each input channel and the output use a valid/ready handshake.
- Selection modes: external select, round-robin, or fixed priority.
- One registered output stage, so paths from the datapath to the output are cut. Used wherever several producers share one consumer.

Parameters:
- WIDTH, 8, data width per channel (>=1).
- N, 4, number of input channels (2..16).
- MODE, 1, selection mode: 0 = external sel, 1 = round-robin, 2 = fixed priority (lowest index wins).
- SEL_W, derived localparam = max(1, clog2(N)), width of sel and out_chan. Not user-overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  SEL_W  channel select, used only when MODE=0.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready, combinational.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SEL_W  index of the channel that supplied out_data (registered).

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0:
  - out_valid=0, out_data=0, out_chan=0, rr pointer=0.
  - in_ready is all zeros.
  - Reset asserted mid-transfer discards the held word immediately; there is no partial state after release.
- load = !out_valid || out_ready. The output register can accept a word this cycle.
- Grant: a one-hot grant[N] is computed combinationally from in_valid and the mode.
  - MODE 0: grant[sel]=in_valid[sel]. If sel>=N, no grant.
  - MODE 1: the first valid channel searching upward from the pointer, wrapping N-1 -> 0.
  - MODE 2: the lowest-index valid channel.
- in_ready[i] = load && grant[i]. At most one bit is set. in_ready must not depend on in_data.
- Transfer on a cycle with in_valid[g] && in_ready[g]. At the next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- Drain only: out_valid && out_ready with no transfer gives out_valid <= 0 at the next edge. out_data and out_chan hold their values.
- Simultaneous drain and load in one cycle: new word loaded, out_valid stays 1. Full throughput of 1 word/clk.
- Stall: while out_valid && !out_ready, out_data, out_chan and out_valid are stable and in_ready is all zeros.
- Latency: exactly 1 clk from input handshake to out_valid.
- Round-robin pointer updates only on a transfer: ptr <= (g==N-1) ? 0 : g+1. There is no update on idle or stall cycles.
- Input valids may drop without handshake. The block tolerates this and the grant simply re-evaluates.
- sel changes during a stall do not disturb the held output.
- Non-power-of-2 N: pointer wrap and sel range checks use N, not 2^SEL_W.

Decomposition:
- Package mux_n_pkg:
  - mode constants MUX_MODE_SEL=0, MUX_MODE_RR=1, MUX_MODE_PRIO=2.
  - clog2 helper function.
- Sub-module rr_arbiter (params N; inputs req[N], ptr[SEL_W]; outputs grant[N] one-hot, gidx[SEL_W], any):
  - combinational rotate-search-unrotate.
  - MODE 2 reuses it with ptr tied to 0.
- Top level holds the pointer, the output register and the mode mux.

Test Plan:
- Reset/idle (N=4, WIDTH=8): assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_chan drop to 0 asynchronously before the next edge; after release with no in_valid -> out_valid stays 0 and in_ready=0000.
- MODE 1, all four channels valid continuously (data 0xA0..0xA3), out_ready=1 -> out_chan sequence 0,1,2,3,0,... one word per clk, out_data 0xA0,0xA1,0xA2,0xA3,... first word 1 clk after the first handshake.
- MODE 1, only ch1 and ch3 valid -> out_chan alternates 1,3,1,3; then drop ch3 -> ch1 every cycle with no bubbles; pointer wraps 3->0 correctly.
- Backpressure, MODE 2: ch0=0x11, ch2=0x22 valid, out_ready=0 for 3 clks -> out_data=0x11, out_chan=0 held stable, in_ready=0000 during the stall; release -> ch0 is served repeatedly while valid (starvation of ch2 by design).
- MODE 0 with N=3: sel=2 and ch2 valid -> grant ch2 with out_data equal to ch2 data; sel=3 (out of range) -> no grant, out_valid falls after drain; sel toggled during a stall -> held output unchanged.
- Randomised valid/ready scoreboard in all modes: every accepted input word appears exactly once, in order per channel, with the correct out_chan; no in_ready bit is set while stalled.
